// File: rtl/ncsp_mash_ctrl.sv
// ncsp_mash_ctrl
// Sequencing and configuration controller for the three-level NCSP MASH
// modulator. It takes config words over a valid/ready handshake, drives the
// modulator's ff-reset / reset-release sequence so the staggered reset tree
// clears and releases in order, and applies live level updates coherently:
// all three levels change on the same edge.
//
// Phase timing: the phase counter is loaded with the phase length on entry
// and the phase ends when the counter reads 1, so each phase is visible for
// exactly its parameter's number of cycles. Control outputs are registered
// from the next-state decode, so they change on the same edge as the state
// register and never glitch.

module ncsp_mash_ctrl #(
  parameter int P_FFRST_CYC  = 2,
  parameter int P_HOLD_CYC   = 8,
  parameter int P_SETTLE_CYC = 8,
  parameter int P_CNT_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic        i_cfg_restart,
  input  logic [7:0]  i_cfg_level1,
  input  logic [7:0]  i_cfg_level2,
  input  logic [7:0]  i_cfg_level3,
  input  logic [11:0] i_cfg_seed,
  input  logic [7:0]  i_cfg_sum_sel,
  input  logic [8:0]  i_cfg_cout_sel,
  output logic        o_mash_ff_rst,
  output logic        o_mash_rst_n,
  output logic [7:0]  o_level1,
  output logic [7:0]  o_level2,
  output logic [7:0]  o_level3,
  output logic [11:0] o_seed,
  output logic [7:0]  o_sum_sel,
  output logic [8:0]  o_cout_sel,
  output logic        o_running,
  output logic        o_busy
);

  // Full configuration word as held in the output registers.
  typedef struct packed {
    logic [7:0]  level1;
    logic [7:0]  level2;
    logic [7:0]  level3;
    logic [11:0] seed;
    logic [7:0]  sum_sel;
    logic [8:0]  cout_sel;
  } cfg_t;

  typedef enum logic [2:0] {
    S_OFF,
    S_FFRST,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam logic [P_CNT_W-1:0] LP_FFRST_LEN  = P_CNT_W'(P_FFRST_CYC);
  localparam logic [P_CNT_W-1:0] LP_HOLD_LEN   = P_CNT_W'(P_HOLD_CYC);
  localparam logic [P_CNT_W-1:0] LP_SETTLE_LEN = P_CNT_W'(P_SETTLE_CYC);
  localparam logic [P_CNT_W-1:0] LP_CNT_ONE    = P_CNT_W'(1);

  state_t              state, state_nxt;
  logic [P_CNT_W-1:0]  cnt;
  logic [P_CNT_W-1:0]  cnt_len;
  logic                phase_done;

  cfg_t                cfg_in, cfg_q;
  logic                cfg_loaded;
  logic                cfg_acc;
  logic                cfg_full_ld;

  logic                ff_rst_d, rst_n_d, busy_d, running_d, ready_d;

  // Handshake: ready is a registered decode of the state, so acceptance
  // depends only on registered signals plus i_cfg_valid.
  assign cfg_acc     = i_cfg_valid & o_cfg_ready;
  // Every accept in OFF and every restart accept loads the whole word;
  // a hot accept in RUN only touches the levels.
  assign cfg_full_ld = cfg_acc & ((state == S_OFF) | i_cfg_restart);
  assign phase_done  = (cnt == LP_CNT_ONE);

  assign cfg_in = {i_cfg_level1, i_cfg_level2, i_cfg_level3,
                   i_cfg_seed, i_cfg_sum_sel, i_cfg_cout_sel};

  // State register and phase counter (counter loads only on state change).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= cnt_len;
      else if (cnt != '0)
        cnt <= cnt - LP_CNT_ONE;
    end
  end

  // Next-state: enable low always wins and parks the modulator in OFF.
  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF: begin
        if (i_enable && (cfg_loaded || cfg_acc))
          state_nxt = S_FFRST;
      end
      S_FFRST: begin
        if (!i_enable)       state_nxt = S_OFF;
        else if (phase_done) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!i_enable)       state_nxt = S_OFF;
        else if (phase_done) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!i_enable)       state_nxt = S_OFF;
        else if (phase_done) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!i_enable)                    state_nxt = S_OFF;
        else if (cfg_acc && i_cfg_restart) state_nxt = S_FFRST;
      end
      default: state_nxt = S_OFF;
    endcase
  end

  // Phase length loaded into the counter on entry to each timed phase.
  always_comb begin
    cnt_len = '0;
    case (state_nxt)
      S_FFRST:   cnt_len = LP_FFRST_LEN;
      S_HOLD:    cnt_len = LP_HOLD_LEN;
      S_RELEASE: cnt_len = LP_SETTLE_LEN;
      default:   cnt_len = '0;
    endcase
  end

  // Output decode from the next state; registered below.
  always_comb begin
    ff_rst_d  = 1'b1;
    rst_n_d   = 1'b0;
    busy_d    = 1'b0;
    running_d = 1'b0;
    ready_d   = 1'b1;
    case (state_nxt)
      S_OFF: begin
        ff_rst_d = 1'b1;
        rst_n_d  = 1'b0;
      end
      S_FFRST: begin
        ff_rst_d = 1'b1;
        rst_n_d  = 1'b0;
        busy_d   = 1'b1;
        ready_d  = 1'b0;
      end
      S_HOLD: begin
        ff_rst_d = 1'b0;
        rst_n_d  = 1'b0;
        busy_d   = 1'b1;
        ready_d  = 1'b0;
      end
      S_RELEASE: begin
        ff_rst_d = 1'b0;
        rst_n_d  = 1'b1;
        busy_d   = 1'b1;
        ready_d  = 1'b0;
      end
      S_RUN: begin
        ff_rst_d  = 1'b0;
        rst_n_d   = 1'b1;
        running_d = 1'b1;
      end
      default: begin
        ff_rst_d = 1'b1;
        rst_n_d  = 1'b0;
      end
    endcase
  end

  // Control output registers; reset holds the modulator fully in reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mash_ff_rst <= 1'b1;
      o_mash_rst_n  <= 1'b0;
      o_busy        <= 1'b0;
      o_running     <= 1'b0;
      o_cfg_ready   <= 1'b1;
    end else begin
      o_mash_ff_rst <= ff_rst_d;
      o_mash_rst_n  <= rst_n_d;
      o_busy        <= busy_d;
      o_running     <= running_d;
      o_cfg_ready   <= ready_d;
    end
  end

  // Config registers: levels move together in one write so the modulator
  // never sees a mix of old and new levels. Config survives enable drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg_q      <= '0;
      cfg_loaded <= 1'b0;
    end else if (cfg_full_ld) begin
      cfg_q      <= cfg_in;
      cfg_loaded <= 1'b1;
    end else if (cfg_acc) begin
      cfg_q.level1 <= cfg_in.level1;
      cfg_q.level2 <= cfg_in.level2;
      cfg_q.level3 <= cfg_in.level3;
    end
  end

  assign o_level1   = cfg_q.level1;
  assign o_level2   = cfg_q.level2;
  assign o_level3   = cfg_q.level3;
  assign o_seed     = cfg_q.seed;
  assign o_sum_sel  = cfg_q.sum_sel;
  assign o_cout_sel = cfg_q.cout_sel;

endmodule

// File: tb/tb_ncsp_mash_ctrl.sv
// Directed testbench for ncsp_mash_ctrl (default parameters).
// Control outputs are checked as one vector {ff_rst, rst_n, busy, running,
// ready}; expected values are hand-derived constants.

module tb_ncsp_mash_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic        i_cfg_restart;
  logic [7:0]  i_cfg_level1, i_cfg_level2, i_cfg_level3;
  logic [11:0] i_cfg_seed;
  logic [7:0]  i_cfg_sum_sel;
  logic [8:0]  i_cfg_cout_sel;
  logic        o_mash_ff_rst, o_mash_rst_n;
  logic [7:0]  o_level1, o_level2, o_level3;
  logic [11:0] o_seed;
  logic [7:0]  o_sum_sel;
  logic [8:0]  o_cout_sel;
  logic        o_running, o_busy;

  int total = 0;
  int bad   = 0;

  // {ff_rst, rst_n, busy, running, ready}
  localparam logic [4:0] C_OFF     = 5'b10001;
  localparam logic [4:0] C_FFRST   = 5'b10100;
  localparam logic [4:0] C_HOLD    = 5'b00100;
  localparam logic [4:0] C_RELEASE = 5'b01100;
  localparam logic [4:0] C_RUN     = 5'b01011;

  logic [4:0]  ctl;
  logic [23:0] lvls;
  assign ctl  = {o_mash_ff_rst, o_mash_rst_n, o_busy, o_running, o_cfg_ready};
  assign lvls = {o_level1, o_level2, o_level3};

  ncsp_mash_ctrl dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_cfg_valid    (i_cfg_valid),
    .o_cfg_ready    (o_cfg_ready),
    .i_cfg_restart  (i_cfg_restart),
    .i_cfg_level1   (i_cfg_level1),
    .i_cfg_level2   (i_cfg_level2),
    .i_cfg_level3   (i_cfg_level3),
    .i_cfg_seed     (i_cfg_seed),
    .i_cfg_sum_sel  (i_cfg_sum_sel),
    .i_cfg_cout_sel (i_cfg_cout_sel),
    .o_mash_ff_rst  (o_mash_ff_rst),
    .o_mash_rst_n   (o_mash_rst_n),
    .o_level1       (o_level1),
    .o_level2       (o_level2),
    .o_level3       (o_level3),
    .o_seed         (o_seed),
    .o_sum_sel      (o_sum_sel),
    .o_cout_sel     (o_cout_sel),
    .o_running      (o_running),
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_cfg(input logic restart, input logic [7:0] l1, input logic [7:0] l2,
                           input logic [7:0] l3, input logic [11:0] seed,
                           input logic [7:0] ssel, input logic [8:0] csel);
    i_cfg_valid    = 1'b1;
    i_cfg_restart  = restart;
    i_cfg_level1   = l1;
    i_cfg_level2   = l2;
    i_cfg_level3   = l3;
    i_cfg_seed     = seed;
    i_cfg_sum_sel  = ssel;
    i_cfg_cout_sel = csel;
  endtask

  function automatic logic [4:0] exp_seq(input int k);
    if (k <= 2)       return C_FFRST;
    else if (k <= 10) return C_HOLD;
    else if (k <= 18) return C_RELEASE;
    else              return C_RUN;
  endfunction

  // Walks edges 1..19 after the edge that leaves OFF/RUN is about to happen.
  // With junk=1, a restart write is held on valid while ready is low; it
  // must never be taken.
  task automatic seq_check(input string tag, input bit junk);
    for (int k = 1; k <= 19; k++) begin
      tick();
      check($sformatf("%s_k%0d", tag, k), {27'd0, ctl}, {27'd0, exp_seq(k)});
      if (k == 1) begin
        i_cfg_valid = 1'b0;
        if (junk) drive_cfg(1'b1, 8'hEE, 8'hEE, 8'hEE, 12'hEEE, 8'hEE, 9'h0EE);
      end
      if (k == 18) i_cfg_valid = 1'b0;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b0;
    drive_cfg(1'b0, 8'h00, 8'h00, 8'h00, 12'h000, 8'h00, 9'h000);
    i_cfg_valid = 1'b0;
    tick();
    tick();
    check("rst_ctl",  {27'd0, ctl}, {27'd0, C_OFF});
    check("rst_lvls", {8'd0, lvls}, 32'h0);
    check("rst_seed", {20'd0, o_seed}, 32'h0);
    i_rst = 1'b0;

    // 1: config write while disabled stays OFF
    drive_cfg(1'b0, 8'h10, 8'h20, 8'h30, 12'hA5C, 8'h5A, 9'h1A5);
    tick();
    i_cfg_valid = 1'b0;
    check("s1_lvls", {8'd0, lvls}, 32'h00102030);
    check("s1_seed", {20'd0, o_seed}, 32'hA5C);
    check("s1_sum",  {24'd0, o_sum_sel}, 32'h5A);
    check("s1_cout", {23'd0, o_cout_sel}, 32'h1A5);
    tick(); tick();
    check("s1_ctl",  {27'd0, ctl}, {27'd0, C_OFF});

    // 2: cold start from stored config
    i_enable = 1'b1;
    seq_check("s2", 1'b0);

    // 3: hot level update, other fields discarded
    drive_cfg(1'b0, 8'h11, 8'h22, 8'h33, 12'hFFF, 8'h00, 9'h000);
    #1;
    check("s3_nocomb", {8'd0, lvls}, 32'h00102030);
    tick();
    i_cfg_valid = 1'b0;
    check("s3_lvls", {8'd0, lvls}, 32'h00112233);
    check("s3_seed", {20'd0, o_seed}, 32'hA5C);
    check("s3_sum",  {24'd0, o_sum_sel}, 32'h5A);
    check("s3_cout", {23'd0, o_cout_sel}, 32'h1A5);
    check("s3_ctl",  {27'd0, ctl}, {27'd0, C_RUN});

    // 4: restart write, full sequence, writes during sequence ignored
    drive_cfg(1'b1, 8'h44, 8'h55, 8'h66, 12'h123, 8'h77, 9'h1FF);
    seq_check("s4", 1'b1);
    check("s4_lvls", {8'd0, lvls}, 32'h00445566);
    check("s4_seed", {20'd0, o_seed}, 32'h123);
    check("s4_sum",  {24'd0, o_sum_sel}, 32'h77);
    check("s4_cout", {23'd0, o_cout_sel}, 32'h1FF);

    // 5: enable low in RUN, then drop enable mid-HOLD, then re-enable
    i_enable = 1'b0;
    tick();
    check("s5_off_run", {27'd0, ctl}, {27'd0, C_OFF});
    i_enable = 1'b1;
    repeat (5) tick();
    check("s5_hold", {27'd0, ctl}, {27'd0, C_HOLD});
    i_enable = 1'b0;
    tick();
    check("s5_off_hold", {27'd0, ctl}, {27'd0, C_OFF});
    check("s5_keep_lvls", {8'd0, lvls}, 32'h00445566);
    check("s5_keep_seed", {20'd0, o_seed}, 32'h123);
    i_enable = 1'b1;
    seq_check("s5", 1'b0);

    // enable low with a hot write in the same RUN cycle: taken, then OFF
    i_enable = 1'b0;
    drive_cfg(1'b0, 8'h99, 8'hAA, 8'hBB, 12'h456, 8'h01, 9'h002);
    tick();
    i_cfg_valid = 1'b0;
    check("en_wr_ctl",  {27'd0, ctl}, {27'd0, C_OFF});
    check("en_wr_lvls", {8'd0, lvls}, 32'h0099AABB);
    check("en_wr_seed", {20'd0, o_seed}, 32'h123);

    // 6: reset during RELEASE clears config and cfg_loaded
    i_enable = 1'b1;
    repeat (12) tick();
    check("s6_release", {27'd0, ctl}, {27'd0, C_RELEASE});
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("s6_rst_ctl",  {27'd0, ctl}, {27'd0, C_OFF});
    check("s6_rst_lvls", {8'd0, lvls}, 32'h0);
    check("s6_rst_seed", {20'd0, o_seed}, 32'h0);
    check("s6_rst_cout", {23'd0, o_cout_sel}, 32'h0);
    repeat (3) tick();
    check("s6_stay_off", {27'd0, ctl}, {27'd0, C_OFF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
